// File: rtl/alu_issue_decode.sv
// Decode/issue stage for RV32I OP, OP-IMM and LUI instructions.
// It owns the integer register file and a busy-bit scoreboard. Decoded ALU
// operations leave through a single output register with a valid/ready
// handshake.
module alu_issue_decode #(
    parameter int DATA_WIDTH = 32,
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic                  CK_REF,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [31:0]           INSTR,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [3:0]            OP_VAL,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [4:0]            RD,
    output logic                  ILLEGAL,
    input  logic                  WB_EN,
    input  logic [4:0]            WB_RD,
    input  logic [DATA_WIDTH-1:0] WB_DATA
);
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Instruction fields
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd_f, rs1, rs2;
    assign opcode = INSTR[6:0];
    assign rd_f   = INSTR[11:7];
    assign funct3 = INSTR[14:12];
    assign rs1    = INSTR[19:15];
    assign rs2    = INSTR[24:20];
    assign funct7 = INSTR[31:25];

    // State
    logic [31:0][DATA_WIDTH-1:0] rf_q, rf_d;
    logic [31:0]                 busy_q, busy_d;
    logic                        out_valid_q, out_valid_d;
    logic                        illegal_q, illegal_d;
    logic [3:0]                  op_q, op_d;
    logic [DATA_WIDTH-1:0]       a_q, a_d, b_q, b_d;
    logic [4:0]                  rd_q, rd_d;

    // Decode
    logic                  is_op, is_imm, is_lui, dec_illegal, use_rs1, use_rs2;
    logic [3:0]            dec_op;
    logic                  fwd1, fwd2, hazard, in_xfer, out_xfer;
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val, op_a, op_b;

    assign is_op  = (opcode == OPC_OP);
    assign is_imm = (opcode == OPC_IMM);
    assign is_lui = (opcode == OPC_LUI);

    // Classify legality, pick the ALU opcode and which sources are read
    always_comb begin
        dec_illegal = 1'b0;
        if (is_op) begin
            if (funct7 == F7_ALT) dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
            else if (funct7 != 7'b0) dec_illegal = 1'b1;
        end else if (is_imm) begin
            if (funct3 == 3'b001 && funct7 != 7'b0) dec_illegal = 1'b1;
            if (funct3 == 3'b101 && funct7 != 7'b0 && funct7 != F7_ALT) dec_illegal = 1'b1;
        end else if (!is_lui) begin
            dec_illegal = 1'b1;
        end
        case (funct3)
            3'b000:  dec_op = (is_op && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b001:  dec_op = ALU_SLL;
            3'b010:  dec_op = ALU_SLT;
            3'b011:  dec_op = ALU_SLTU;
            3'b100:  dec_op = ALU_XOR;
            3'b101:  dec_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  dec_op = ALU_OR;
            default: dec_op = ALU_AND;
        endcase
        if (is_lui) dec_op = ALU_ADD;
        if (dec_illegal) dec_op = ALU_NOP;
        use_rs1 = !dec_illegal && (is_op || is_imm);
        use_rs2 = !dec_illegal && is_op;
    end

    // Register reads with optional same-cycle writeback bypass; x0 is hardwired
    always_comb begin
        fwd1 = FORWARD_EN && WB_EN && (WB_RD == rs1);
        fwd2 = FORWARD_EN && WB_EN && (WB_RD == rs2);
        rs1_val = fwd1 ? WB_DATA : rf_q[rs1];
        rs2_val = fwd2 ? WB_DATA : rf_q[rs2];
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
        op_a = is_lui ? '0 : rs1_val;
        if (is_op)
            op_b = rs2_val;
        else if (is_lui)
            op_b = {INSTR[31:12], 12'b0};
        else if (funct3 == 3'b001 || funct3 == 3'b101)
            op_b = {{(DATA_WIDTH-5){1'b0}}, INSTR[24:20]};
        else
            op_b = {{(DATA_WIDTH-12){INSTR[31]}}, INSTR[31:20]};
    end

    // Hazard only when a used source is busy and not being bypassed this cycle
    always_comb begin
        hazard = IN_VALID &&
                 ((use_rs1 && busy_q[rs1] && !fwd1) || (use_rs2 && busy_q[rs2] && !fwd2));
        IN_READY = (!out_valid_q || OUT_READY) && !hazard;
        in_xfer  = IN_VALID && IN_READY;
        out_xfer = out_valid_q && OUT_READY;
    end

    // Next state: output slot, scoreboard (set beats clear) and register file
    always_comb begin
        out_valid_d = out_valid_q;
        illegal_d   = illegal_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            illegal_d   = dec_illegal;
            op_d        = dec_op;
            rd_d        = dec_illegal ? 5'd0 : rd_f;
            if (!dec_illegal) begin
                a_d = op_a;
                b_d = op_b;
            end
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
            op_d        = ALU_NOP;
        end
        busy_d = busy_q;
        if (WB_EN) busy_d[WB_RD] = 1'b0;
        if (in_xfer && !dec_illegal && rd_f != 5'd0) busy_d[rd_f] = 1'b1;
        rf_d = rf_q;
        if (WB_EN && WB_RD != 5'd0) rf_d[WB_RD] = WB_DATA;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge CK_REF or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            op_q        <= ALU_NOP;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            busy_q      <= '0;
            rf_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            rf_q        <= rf_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign ILLEGAL   = illegal_q;
    assign OP_VAL    = op_q;
    assign A         = a_q;
    assign B         = b_q;
    assign RD        = rd_q;
endmodule

// File: tb/tb_alu_issue_decode.sv
// Bench for alu_issue_decode: a reference model of the issue stage checked
// every cycle, plus directed vectors with hand-computed literals. A second
// instance without bypass shares the stimulus to show the late-accept timing.
module tb_alu_issue_decode;
    logic        CK_REF, RST, IN_VALID, OUT_READY, WB_EN;
    logic [31:0] INSTR, WB_DATA;
    logic [4:0]  WB_RD;
    logic        IN_READY, OUT_VALID, ILLEGAL;
    logic [3:0]  OP_VAL;
    logic [31:0] A, B;
    logic [4:0]  RD;
    logic        IN_READY0, OUT_VALID0, ILLEGAL0;
    logic [3:0]  OP_VAL0;
    logic [31:0] A0, B0;
    logic [4:0]  RD0;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_decode #(.DATA_WIDTH(32), .FORWARD_EN(1'b1)) dut (
        .CK_REF(CK_REF), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTR(INSTR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OP_VAL(OP_VAL), .A(A), .B(B), .RD(RD), .ILLEGAL(ILLEGAL),
        .WB_EN(WB_EN), .WB_RD(WB_RD), .WB_DATA(WB_DATA));

    alu_issue_decode #(.DATA_WIDTH(32), .FORWARD_EN(1'b0)) dut0 (
        .CK_REF(CK_REF), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY0),
        .INSTR(INSTR), .OUT_VALID(OUT_VALID0), .OUT_READY(OUT_READY),
        .OP_VAL(OP_VAL0), .A(A0), .B(B0), .RD(RD0), .ILLEGAL(ILLEGAL0),
        .WB_EN(WB_EN), .WB_RD(WB_RD), .WB_DATA(WB_DATA));

    initial begin
        CK_REF = 1'b0;
        forever #5 CK_REF = ~CK_REF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {K_R, K_I, K_U, K_BAD} kind_e;
    typedef struct {
        kind_e      kind;
        bit         legal;
        logic [3:0] op;
    } dec_t;

    // mnemonic per funct3: add sll slt sltu xor srl or and
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] tbl [8];
        tbl = '{4'b0001, 4'b0111, 4'b0011, 4'b1011, 4'b0110, 4'b1000, 4'b0101, 4'b0100};
        return tbl[f3];
    endfunction

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        d.op = base_op(f3);
        case (ins[6:0])
            7'h33: begin
                d.kind  = K_R;
                d.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                if (f7 == 7'h20 && f3 == 3'd0) d.op = 4'b0010;
                if (f7 == 7'h20 && f3 == 3'd5) d.op = 4'b1001;
            end
            7'h13: begin
                d.kind = K_I;
                if (f3 == 3'd1)      d.legal = (f7 == 7'h00);
                else if (f3 == 3'd5) d.legal = (f7 == 7'h00 || f7 == 7'h20);
                else                 d.legal = 1'b1;
                if (f3 == 3'd5 && f7 == 7'h20) d.op = 4'b1001;
            end
            7'h37: begin
                d.kind  = K_U;
                d.legal = 1'b1;
                d.op    = 4'b0001;
            end
            default: begin
                d.kind  = K_BAD;
                d.legal = 1'b0;
            end
        endcase
        if (!d.legal) d.op = 4'b0000;
        return d;
    endfunction

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic        m_valid, m_ill;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (WB_EN && WB_RD == idx) return WB_DATA;
        return m_regs[idx];
    endfunction

    function automatic bit m_blocked(input logic [4:0] idx);
        return m_busy[idx] && !(WB_EN && WB_RD == idx);
    endfunction

    function automatic bit m_ready();
        dec_t d;
        bit   haz;
        d   = decode(INSTR);
        haz = 1'b0;
        if (IN_VALID && d.legal) begin
            if ((d.kind == K_R || d.kind == K_I) && m_blocked(INSTR[19:15])) haz = 1'b1;
            if (d.kind == K_R && m_blocked(INSTR[24:20])) haz = 1'b1;
        end
        return (!m_valid || OUT_READY) && !haz;
    endfunction

    always @(posedge CK_REF or posedge RST) begin : model
        automatic dec_t d;
        automatic bit   acc;
        if (RST) begin
            m_valid <= 1'b0; m_ill <= 1'b0; m_op <= 4'b0;
            m_a <= '0; m_b <= '0; m_rd <= '0;
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= '0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            d   = decode(INSTR);
            acc = IN_VALID && m_ready();
            if (acc) begin
                m_valid <= 1'b1;
                m_ill   <= !d.legal;
                m_op    <= d.op;
                m_rd    <= d.legal ? INSTR[11:7] : 5'd0;
                if (d.kind == K_U) begin
                    m_a <= 32'd0;
                    m_b <= {INSTR[31:12], 12'h000};
                end else if (d.kind == K_R) begin
                    m_a <= m_read(INSTR[19:15]);
                    m_b <= m_read(INSTR[24:20]);
                end else if (d.kind == K_I && d.legal) begin
                    m_a <= m_read(INSTR[19:15]);
                    if (INSTR[14:12] == 3'd1 || INSTR[14:12] == 3'd5)
                        m_b <= {27'd0, INSTR[24:20]};
                    else
                        m_b <= {{20{INSTR[31]}}, INSTR[31:20]};
                end
            end else if (m_valid && OUT_READY) begin
                m_valid <= 1'b0;
                m_ill   <= 1'b0;
                m_op    <= 4'b0;
            end
            if (WB_EN) m_busy[WB_RD] <= 1'b0;
            if (WB_EN && WB_RD != 5'd0) m_regs[WB_RD] <= WB_DATA;
            if (acc && d.legal && INSTR[11:7] != 5'd0) m_busy[INSTR[11:7]] <= 1'b1;
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge CK_REF) begin
        chk("cyc_out_valid", {31'd0, OUT_VALID}, {31'd0, m_valid});
        chk("cyc_illegal", {31'd0, ILLEGAL}, {31'd0, m_ill});
        chk("cyc_op_val", {28'd0, OP_VAL}, {28'd0, m_op});
        chk("cyc_rd", {27'd0, RD}, {27'd0, m_rd});
        chk("cyc_in_ready", {31'd0, IN_READY}, {31'd0, m_ready()});
        if (m_valid && !m_ill) begin
            chk("cyc_a", A, m_a);
            chk("cyc_b", B, m_b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CK_REF);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        IN_VALID = 1'b1;
        INSTR = ins;
        while (!acc && n < 20) begin
            @(negedge CK_REF);
            acc = IN_READY;
            tick();
            n++;
        end
        chk("issue_accept", {31'd0, acc}, 32'd1);
        IN_VALID = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] v);
        WB_EN = 1'b1; WB_RD = r; WB_DATA = v;
        tick();
        WB_EN = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] r);
        chk({name, "_valid"}, {31'd0, OUT_VALID}, 32'd1);
        chk({name, "_op"}, {28'd0, OP_VAL}, {28'd0, op});
        chk({name, "_a"}, A, a);
        chk({name, "_b"}, B, b);
        chk({name, "_rd"}, {27'd0, RD}, {27'd0, r});
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; INSTR = '0; OUT_READY = 1'b1;
        WB_EN = 1'b0; WB_RD = '0; WB_DATA = '0;
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_op", {28'd0, OP_VAL}, 32'd0);
        chk("rst_ab", A | B, 32'd0);
        chk("rst_rd_ill", {26'd0, RD, ILLEGAL}, 32'd0);
        RST = 1'b0;
        tick();

        // addi x1,x0,5
        issue(32'h00500093);
        expect_out("addi", 4'b0001, 32'd0, 32'd5, 5'd1);

        // add x2,x1,x1 waits on busy x1; bypass lets it go in the writeback cycle
        IN_VALID = 1'b1; INSTR = 32'h00108133;
        @(negedge CK_REF); chk("haz_ready_c0", {31'd0, IN_READY}, 32'd0);
        tick();
        @(negedge CK_REF); chk("haz_ready_c1", {31'd0, IN_READY}, 32'd0);
        tick();
        WB_EN = 1'b1; WB_RD = 5'd1; WB_DATA = 32'd9;
        @(negedge CK_REF);
        chk("fwd_ready", {31'd0, IN_READY}, 32'd1);
        chk("nofwd_ready_wb", {31'd0, IN_READY0}, 32'd0);
        tick();
        WB_EN = 1'b0;
        expect_out("fwd_add", 4'b0001, 32'd9, 32'd9, 5'd2);
        @(negedge CK_REF);
        chk("nofwd_ready_late", {31'd0, IN_READY0}, 32'd1);
        tick();
        IN_VALID = 1'b0;

        // sub x3,x1,x2
        wb(5'd1, 32'd7);
        wb(5'd2, 32'd3);
        issue(32'h402081B3);
        expect_out("sub", 4'b0010, 32'd7, 32'd3, 5'd3);

        // srai x4,x1,3 and lui x5
        wb(5'd1, 32'h80000000);
        issue(32'h4030D213);
        expect_out("srai", 4'b1001, 32'h80000000, 32'd3, 5'd4);
        issue(32'h123452B7);
        expect_out("lui", 4'b0001, 32'd0, 32'h12345000, 5'd5);
        chk("pin_model_lui_b", m_b, 32'h12345000);

        // sltiu x6,x0,-1 compares against sign-extended immediate
        issue(32'hFFF03313);
        expect_out("sltiu", 4'b1011, 32'd0, 32'hFFFFFFFF, 5'd6);

        // illegal: all-zero word, R-type alt funct7 on sll, slli with funct7 set
        issue(32'h00000000);
        chk("ill0_flag", {31'd0, ILLEGAL}, 32'd1);
        chk("ill0_op_rd", {23'd0, OP_VAL, RD}, 32'd0);
        chk("ill0_valid", {31'd0, OUT_VALID}, 32'd1);
        issue(32'h40209133);
        chk("ill_rtype_flag", {31'd0, ILLEGAL}, 32'd1);
        issue(32'h40109093);
        chk("ill_slli_flag", {31'd0, ILLEGAL}, 32'd1);
        chk("pin_model_ill", {31'd0, m_ill}, 32'd1);

        // x0 is never written
        wb(5'd0, 32'h55);
        issue(32'h000003B3);
        expect_out("x0", 4'b0001, 32'd0, 32'd0, 5'd7);

        // andi x8,x0,0xF0 then stall with ori pending
        issue(32'h0F007413);
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; INSTR = 32'h00106493;
        repeat (3) begin
            @(negedge CK_REF);
            chk("stall_ready", {31'd0, IN_READY}, 32'd0);
            expect_out("stall", 4'b0100, 32'd0, 32'h000000F0, 5'd8);
            tick();
        end
        #1;
        RST = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_mid_op", {28'd0, OP_VAL}, 32'd0);
        tick();
        RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        tick();
        // add x10,x1,x2 after reset: registers read 0, x4 no longer busy
        issue(32'h00208533);
        expect_out("post_rst", 4'b0001, 32'd0, 32'd0, 5'd10);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_issue_decode.md
Name: alu_issue_decode

Overview:
Decode/issue stage that drives the ALU's operation and operand inputs. It accepts 32-bit RV32I instructions of type OP, OP-IMM and LUI, reads the integer register file it owns, and resolves immediates. Issue is one output register stage with valid/ready handshakes, plus a busy-bit scoreboard and a writeback port back from the ALU/writeback stage.

Parameters:
DATA_WIDTH, 32, operand/register width (only 32 supported)
FORWARD_EN, 1, 1 = same-cycle writeback bypass clears a hazard; 0 = stall until the cycle after writeback

Ports:
CK_REF  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
IN_VALID  in  1  INSTR is valid
IN_READY  out  1  stage accepts INSTR this cycle
INSTR  in  32  RV32I instruction word
OUT_VALID  out  1  issued operation valid
OUT_READY  in  1  downstream accepts the issued operation
OP_VAL  out  4  ALU opcode: 0001 add, 0010 sub, 0011 slt, 1011 sltu, 0100 and, 0101 or, 0110 xor, 0111 sll, 1000 srl, 1001 sra, 0000 bubble
A  out  32  ALU operand A
B  out  32  ALU operand B
RD  out  5  destination register
ILLEGAL  out  1  issued slot is an illegal instruction
WB_EN  in  1  writeback strobe
WB_RD  in  5  writeback register index
WB_DATA  in  32  writeback value

Behaviour:
- Reset (async, RST=1): OUT_VALID=0, OP_VAL=0000, A=0, B=0, RD=0, ILLEGAL=0; all 32 registers =0; busy vector =0. Takes effect immediately mid-operation; any in-flight output is dropped.
- Handshakes: input transfer on IN_VALID&IN_READY; output transfer on OUT_VALID&OUT_READY. OUT_* hold stable while OUT_VALID&!OUT_READY.
- IN_READY = (!OUT_VALID | OUT_READY) & !hazard. Combinational from OUT_READY, WB_* and INSTR.
- Latency: accepted instruction appears on outputs the next cycle. Sustains 1 instruction/cycle with no hazards.
- OUT_VALID=0 when not issuing: OP_VAL=0000, ILLEGAL=0, A/B/RD unchanged.
- Decode by funct3:
  - 000: add (sub when R-type with funct7=0100000)
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: srl, or sra when funct7=0100000
  - 110: or
  - 111: and
- Operands:
  - R-type: A=rs1 value, B=rs2 value.
  - OP-IMM: A=rs1 value, B=sign-extended imm[11:0]. For slli/srli/srai, B={27'b0,shamt}.
  - LUI: OP_VAL=0001, A=0, B={imm[31:12],12'b0}.
  - sltiu compares against the sign-extended immediate.
- Illegal instructions:
  - Triggers: opcode not in {0110011, 0010011, 0110111}; R-type funct7 not 0000000, or 0100000 outside funct3 000/101; slli funct7≠0000000; srli/srai funct7 not 0000000/0100000.
  - Response: issued with OUT_VALID=1, ILLEGAL=1, OP_VAL=0000, RD=0. No register read, no busy bit set.
- Register file:
  - x0 reads 0 and is never written. Writes occur when WB_EN & WB_RD≠0.
  - Read during a same-cycle write of the same index returns WB_DATA when FORWARD_EN=1.
- Scoreboard:
  - busy[rd] is set on input transfer when rd≠0 and the instruction is legal; cleared on WB_EN for WB_RD.
  - Same-cycle set and clear of the same index: set wins.
  - hazard = any used source (rs1; rs2 for R-type; none for LUI) with busy=1, unless FORWARD_EN=1 & WB_EN & WB_RD matches that source.
  - Hazards are evaluated only while IN_VALID=1.
- WB_EN to a non-busy register still writes the register file. Busy is unaffected.

Test Plan:
- Reset, then INSTR=0x00500093 (addi x1,x0,5), OUT_READY=1 -> next cycle: OUT_VALID=1, OP_VAL=0001, A=0, B=5, RD=1; busy[1]=1.
- After WB x1=7 and x2=3 with busy clear, INSTR=0x402081B3 (sub x3,x1,x2) -> OP_VAL=0010, A=7, B=3, RD=3.
- x1=0x80000000, INSTR=0x4030D213 (srai x4,x1,3) -> OP_VAL=1001, B=3. INSTR=0x123452B7 (lui x5) -> OP_VAL=0001, A=0, B=0x12345000.
- Issue addi x1, then INSTR=0x00108133 (add x2,x1,x1) held valid -> IN_READY=0 until WB_EN=1, WB_RD=1, WB_DATA=9 (FORWARD_EN=1). It is accepted in that same cycle, issuing A=9, B=9. With FORWARD_EN=0 it is accepted one cycle later.
- INSTR=0x00000000 -> OUT_VALID=1, ILLEGAL=1, OP_VAL=0000, RD=0; busy unchanged.
- OUT_READY=0 for 3 cycles with valid input -> outputs stable, IN_READY=0. Assert RST mid-stall -> OUT_VALID=0 and OP_VAL=0000 immediately, registers read 0 afterwards.
